// File: rtl/spi_pkg.sv
// spi_pkg: controller state encoding and divider-width helper shared by the SPI controller files.
package spi_pkg;
    typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL, GAP} spi_ctrl_state_t;
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/spi_clk_tick.sv
// spi_clk_tick: half-period divider; tick marks the last clk cycle of each sck half-period.
module spi_clk_tick import spi_pkg::*; #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);
    localparam int CW = cnt_w(CLK_DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    assign tick = en && (cnt_q == CW'(CLK_DIV - 1));
    always_comb cnt_d = (!en || tick) ? '0 : cnt_q + CW'(1);
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/spi_controller.sv
// spi_controller: mode-0 SPI initiator, one full-duplex DATA_WIDTH word per start.
// Define SPI_CONTROLLER_LSB_FIRST_EN to shift LSB first in both directions.
module spi_controller import spi_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  busy,
    output logic                  done,
    output logic                  cs,
    output logic                  sck,
    output logic                  mosi,
    input  logic                  miso
);
`ifdef SPI_CONTROLLER_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif
    localparam int BW = cnt_w(DATA_WIDTH);

    spi_ctrl_state_t state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic cs_q, cs_d, sck_q, sck_d, mosi_q, mosi_d, busy_q, busy_d, done_q, done_d;
    logic tick;

    spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .reset(reset),
        .en   (state_q != IDLE),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        bit_cnt_d = bit_cnt_q;
        cs_d      = cs_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: if (start && !busy_q) begin
                tx_sh_d   = tx_data;
                mosi_d    = LSB ? tx_data[0] : tx_data[DATA_WIDTH-1];
                cs_d      = 1'b0;
                busy_d    = 1'b1;
                bit_cnt_d = '0;
                state_d   = LEAD;
            end
            LEAD, LOW: if (tick) begin
                sck_d   = 1'b1;
                rx_sh_d = LSB ? {miso, rx_sh_q[DATA_WIDTH-1:1]} : {rx_sh_q[DATA_WIDTH-2:0], miso};
                state_d = HIGH;
            end
            HIGH: if (tick) begin
                sck_d = 1'b0;
                if (bit_cnt_q == BW'(DATA_WIDTH - 1)) state_d = TRAIL;
                else begin
                    mosi_d    = LSB ? tx_sh_q[1] : tx_sh_q[DATA_WIDTH-2];
                    tx_sh_d   = LSB ? tx_sh_q >> 1 : tx_sh_q << 1;
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    state_d   = LOW;
                end
            end
            TRAIL: if (tick) begin
                cs_d    = 1'b1;
                mosi_d  = 1'b0;
                state_d = GAP;
            end
            GAP: if (tick) begin
                busy_d    = 1'b0;
                done_d    = 1'b1;
                rx_data_d = rx_sh_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            bit_cnt_q <= '0;
            cs_q      <= 1'b1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            bit_cnt_q <= bit_cnt_d;
            cs_q      <= cs_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rx_data = rx_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign cs      = cs_q;
    assign sck     = sck_q;
    assign mosi    = mosi_q;
endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
- SPI bus controller (initiator) for the SPI peripheral side of the design; drives cs, sck and mosi, and samples miso.
- Runs one fixed-length full-duplex word transfer per start request.
- Bus mode 0: sck idles low, data is sampled on sck rising and changed on sck falling; MSB first.
- Sits between a local processor or FSM and an off-chip or on-chip SPI peripheral. Generates sck by dividing the system clock.

Parameters:
- DATA_WIDTH, 8, bits per transfer (>=2).
- CLK_DIV, 4, system clk cycles per sck half-period (>=1); sck frequency = f_clk/(2*CLK_DIV).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  transfer request; accepted on a clk edge where busy==0.
- tx_data  input  DATA_WIDTH  word to send; captured only at accept.
- rx_data  output  DATA_WIDTH  last received word; updated in the done cycle, held otherwise.
- busy  output  1  high from the accept edge until the done cycle.
- done  output  1  single-cycle pulse at end of transfer.
- cs  output  1  chip select, active-low (low = peripheral selected); idles high.
- sck  output  1  serial clock; idles low.
- mosi  output  1  serial data out.
- miso  input  1  serial data in; must be stable around sck rising edges.

Behaviour:
- All outputs are registered. No combinational path from inputs to outputs.
- Reset values, applied immediately (async): cs=1, sck=0, mosi=0, busy=0, done=0, rx_data=0, state=IDLE, counters=0.
- States are IDLE, LEAD, HIGH, LOW, TRAIL and GAP. A divider counter counts 0..CLK_DIV-1; "tick" means counter==CLK_DIV-1, and the counter then clears.
- IDLE, start && !busy at edge t0:
  - shift_reg <= tx_data; mosi <= tx_data[DATA_WIDTH-1]; cs <= 0; busy <= 1; bit_cnt <= 0.
  - Next state LEAD.
- LEAD, on tick: sck <= 1; shift miso into the receive shift LSB. Next state HIGH.
- HIGH, on tick: sck <= 0.
  - If bit_cnt==DATA_WIDTH-1, go to TRAIL.
  - Otherwise mosi <= next bit, bit_cnt++, go to LOW.
- LOW, on tick: sck <= 1; sample miso. Next state HIGH.
- TRAIL, on tick: cs <= 1; mosi <= 0. Next state GAP.
- GAP, on tick: busy <= 0; done <= 1 for one cycle; rx_data <= received word. Next state IDLE.
- Timing relative to t0:
  - cs falls at t0.
  - sck rising edges occur at t0 + N*(2k+1), k = 0..DATA_WIDTH-1, where N=CLK_DIV.
  - Last sck fall is at t0 + 2*W*N. cs rises at t0 + (2W+1)*N.
  - done is at t0 + (2W+2)*N.
  - For W=8, N=4: cs rises at t0+68, done at t0+72.
- Guaranteed timing: minimum cs-high time between transfers is N cycles. Exactly DATA_WIDTH sck pulses occur per transfer.
- start while busy is ignored, with no queuing.
- start asserted in the done cycle sees busy==0 and is accepted on the next edge, giving back-to-back transfers.
- tx_data changes after accept have no effect on the current transfer.
- reset mid-transfer aborts it:
  - cs goes high and sck goes low immediately; no done pulse is produced.
  - rx_data returns to 0.
- start held high continuously: a new transfer begins after each done cycle.

Optional Feature:
- Macro: SPI_CONTROLLER_LSB_FIRST_EN.
- Defined:
  - Transmit order: tx_data[0] is sent first.
  - Receive order: the first received bit lands in rx_data[0] and the last in rx_data[DATA_WIDTH-1].
- Undefined (default): MSB first in both directions; the first received bit ends in rx_data[DATA_WIDTH-1].
- Timing is identical either way.

Decomposition:
- Package spi_pkg:
  - typedef enum logic [2:0] spi_ctrl_state_t {IDLE, LEAD, HIGH, LOW, TRAIL, GAP};
  - localparam helper for the divider counter width, $clog2(CLK_DIV) with a minimum of 1.
- Sub-module spi_clk_tick: parameter CLK_DIV; ports clk, reset, en, tick.
  - Free-running half-period counter that clears when en==0.
  - Instantiated once; en = (state != IDLE).

Test Plan:
- Loopback, mosi tied to miso, CLK_DIV=4, tx_data=0xA5.
  - Required: 8 sck pulses; mosi bit sequence 1,0,1,0,0,1,0,1 at the rising edges.
  - Required: done at t0+72; rx_data=0xA5; busy low in the done cycle.
- miso tied to 1 with tx_data=0x00, then miso tied to 0 with tx_data=0xFF.
  - Required: rx_data=0xFF, then 0x00; cs high between transfers for >=4 cycles.
- Behavioural mode-0 peripheral model returning 0x3C while the controller sends 0xC3.
  - Required: peripheral captures 0xC3; rx_data=0x3C.
  - Required: peripheral miso changes only while sck is low.
- start pulsed again at t0+10 with tx_data=0x11 during a 0xA5 transfer.
  - Required: ignored; the wire sequence matches 0xA5 only; exactly one done pulse.
- reset asserted at t0+30 mid-transfer.
  - Required: cs=1, sck=0, busy=0, rx_data=0 within the same cycle; no done.
  - Required: a new start after release gives a clean transfer.
- CLK_DIV=1 with start held high and two words 0x01, 0x80 (tx_data updated at each done).
  - Required: done at t0+18 and t0+37.
  - Required: cs high for exactly 2 cycles between the two transfers.
  - Required: with SPI_CONTROLLER_LSB_FIRST_EN defined, mosi order is reversed and loopback rx_data still equals tx_data.
